// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the pipeline trace buffer.
// Holds the trace FSM state encoding and the timestamp width used when
// TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

  localparam int TS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x ENTRY_W storage for the trace buffer.
// One synchronous write port and one registered read port; contents and
// the read register are deliberately not reset.
module trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 20,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Write the captured sample and register the popped entry on the same edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular capture of per-stage pipeline PC tags.
// Records pc_bus each qualified cycle while armed, keeps POST_TRIG samples
// after a stage-0 trigger match, then allows oldest-first readout.
// Optional macro TRACE_TIMESTAMP_EN appends a 16-bit free-running cycle
// counter in the MSBs of every entry.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int TAG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W   = NUM_STAGES * TAG_W + TS_W
`else
  localparam int ENTRY_W   = NUM_STAGES * TAG_W
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_STAGES*TAG_W-1:0] pc_bus,
  input  logic                        sample_en,
  input  logic                        arm,
  input  logic                        abort,
  input  logic [TAG_W-1:0]            trig_tag,
  input  logic                        rd_req,
  output logic [ENTRY_W-1:0]          rd_data,
  output logic                        rd_valid,
  output logic [CNT_W-1:0]            count,
  output logic [1:0]                  state,
  output logic                        done
);

  localparam int AW = $clog2(DEPTH);

  trace_state_t       st, st_nxt;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt, post_cnt;
  logic               valid_q;
  logic [ENTRY_W-1:0] entry, ram_q;
  logic               capture, trig_hit, leave, we, pop;
  logic [AW-1:0]      waddr;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running cycle counter stamped into each entry, independent of sample_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  assign entry = {ts, pc_bus};
`else
  assign entry = pc_bus;
`endif

  // A restart owns the cycle: the arm sample becomes entry 0 and nothing else happens
  assign capture  = sample_en && ((st == ST_PRE) || (st == ST_POST));
  assign trig_hit = (st == ST_PRE) && sample_en && (pc_bus[TAG_W-1:0] == trig_tag);
  assign leave    = abort && (st != ST_IDLE);
  assign we       = arm ? sample_en : (capture && !leave);
  assign waddr    = arm ? '0 : wr_ptr;
  assign pop      = !arm && !leave && (st == ST_DONE) && rd_req && (cnt != '0);

  trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .AW      (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (entry),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Next-state: arm beats abort, abort beats the trigger and window logic
  always_comb begin
    st_nxt = st;
    if (arm) begin
      st_nxt = ST_PRE;
    end else if (leave) begin
      st_nxt = ST_IDLE;
    end else begin
      case (st)
        ST_PRE: begin
          if (trig_hit) begin
            st_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          if (capture && (post_cnt == CNT_W'(1))) begin
            st_nxt = ST_DONE;
          end
        end
        default: st_nxt = st;
      endcase
    end
  end

  // Pointers, occupancy and post-trigger window; abort freezes all of them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      post_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= pop;
      if (arm) begin
        wr_ptr   <= sample_en ? AW'(1) : '0;
        rd_ptr   <= '0;
        cnt      <= sample_en ? CNT_W'(1) : '0;
        post_cnt <= '0;
      end else if (!leave) begin
        if (we) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (cnt == CNT_W'(DEPTH)) begin
            rd_ptr <= rd_ptr + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        if (trig_hit) begin
          post_cnt <= CNT_W'(POST_TRIG);
        end else if ((st == ST_POST) && capture) begin
          post_cnt <= post_cnt - 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt - 1'b1;
        end
      end
    end
  end

  // Outputs; rd_data reads zero whenever no popped entry is being presented
  always_comb begin
    state    = st;
    done     = (st == ST_DONE);
    count    = cnt;
    rd_valid = valid_q;
    rd_data  = valid_q ? ram_q : '0;
  end

endmodule
